// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the front end of the core.
//   XLEN          : machine word width
//   NOP           : canonical no-op encoding (addi x0, x0, 0)
//   fetch_entry_t : one buffered fetch slot {valid, instruction, pc}
//   nop_fill      : substitutes NOP for the word of an empty slot
package pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h00000013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] nop_fill(input logic vld, input logic [XLEN-1:0] word);
    return vld ? word : NOP;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer (main + skid).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr                 : synchronous discard of both entries and of any
//                         same-cycle input; wins over every other update
//   in_valid/in_ready   : upstream handshake; in_ready is a register equal
//                         to NOT skid-valid
//   in_data             : upstream payload
//   out_valid/out_ready : downstream handshake; out_valid is main-valid
//   out_data            : payload held in main
//   occupancy           : main-valid + skid-valid
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 2 * XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_vld;
  logic              skid_vld;
  logic              rdy;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;

  logic in_xfer;
  logic out_xfer;
  logic main_vld_n;
  logic skid_vld_n;
  logic main_load_in;
  logic main_load_skid;
  logic skid_load;

  // Next-state decision. A skid entry can only exist while main is full, so
  // the cases below are exhaustive for reachable states.
  always_comb begin
    in_xfer        = in_valid & rdy;
    out_xfer       = main_vld & out_ready;
    main_vld_n     = main_vld;
    skid_vld_n     = skid_vld;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (clr) begin
      main_vld_n = 1'b0;
      skid_vld_n = 1'b0;
    end else if (out_xfer) begin
      if (skid_vld) begin
        // in_ready is low here, so no input competes with the move
        main_load_skid = 1'b1;
        skid_vld_n     = 1'b0;
      end else if (in_xfer) begin
        main_load_in = 1'b1;
      end else begin
        main_vld_n = 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_vld) begin
        main_load_in = 1'b1;
        main_vld_n   = 1'b1;
      end else begin
        skid_load  = 1'b1;
        skid_vld_n = 1'b1;
      end
    end
  end

  // Control state: valid bits and the registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy      <= 1'b1;
    end else begin
      main_vld <= main_vld_n;
      skid_vld <= skid_vld_n;
      rdy      <= ~skid_vld_n;
    end
  end

  // Payload registers carry no reset; their contents are qualified by the
  // valid bits above.
  always_ff @(posedge clk) begin
    if (main_load_skid) begin
      main_data <= skid_data;
    end else if (main_load_in) begin
      main_data <= in_data;
    end
    if (skid_load) begin
      skid_data <= in_data;
    end
  end

  assign in_ready  = rdy;
  assign out_valid = main_vld;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: rtl/fetch_pipe.sv
// Fetch-to-decode pipeline register with a one-entry skid.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   flush                      : taken branch/jump; drops buffered and
//                                incoming instructions at the next edge
//   in_valid, in_ready         : handshake with the fetch stage
//   instruction_in, pc_in      : fetched word and its address
//   out_valid, out_ready       : handshake with decode (out_ready drops on
//                                a load-use stall)
//   instruction_out, pc_out    : head instruction; NOP / 0 when empty
//   occupancy                  : buffered entries, 0..2
//   stall_count                : only with FETCH_PIPE_PERF_EN defined; counts
//                                cycles with out_valid high and out_ready low,
//                                cleared only by reset, wraps modulo 2^32
module fetch_pipe
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instruction_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] instruction_out,
  output logic [XLEN-1:0] pc_out,
  output logic [1:0]      occupancy
`ifdef FETCH_PIPE_PERF_EN
  ,
  output logic [31:0]     stall_count
`endif
);

  localparam int DATA_W = 2 * XLEN;

  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;
  fetch_entry_t      head;

  // Flush feeds the buffer's clear, which outranks input, drain and move,
  // so a same-cycle input transfer is discarded as well.
  pipe_skid_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({instruction_in, pc_in}),
    .out_valid(buf_valid),
    .out_ready(out_ready),
    .out_data (buf_data),
    .occupancy(occupancy)
  );

  always_comb begin
    head.valid       = buf_valid;
    head.instruction = buf_data[DATA_W-1:XLEN];
    head.pc          = buf_data[XLEN-1:0];
  end

  // An empty head presents a harmless NOP at address 0 to decode
  assign out_valid       = head.valid;
  assign instruction_out = nop_fill(head.valid, head.instruction);
  assign pc_out          = head.valid ? head.pc : '0;

`ifdef FETCH_PIPE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (head.valid && !out_ready) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pipe.sv
module tb_fetch_pipe;

  localparam logic [31:0] NOPW = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction_in = '0;
  logic [31:0] pc_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [1:0]  occupancy;
`ifdef FETCH_PIPE_PERF_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int failures = 0;

  fetch_pipe dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instruction_in (instruction_in),
    .pc_in          (pc_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .instruction_out(instruction_out),
    .pc_out         (pc_out),
    .occupancy      (occupancy)
`ifdef FETCH_PIPE_PERF_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    logic [1:0]  e_occ;
    logic        e_ir;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ov, input logic [31:0] ins,
                            input logic [31:0] pc, input logic [1:0] occ, input logic ir);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".instruction_out"}, instruction_out, ins);
    chk({tag, ".pc_out"}, pc_out, pc);
    chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] ins,
                       input logic [31:0] pc, input logic ordy);
    flush = fl; in_valid = iv; instruction_in = ins; pc_in = pc; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outs("reset", 1'b0, NOPW, 32'd0, 2'd0, 1'b1);
`ifdef FETCH_PIPE_PERF_EN
    chk("reset.stall_count", stall_count, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: an ordered list of at most two buffered words.
  logic [63:0] mq[$];
  int unsigned m_stall;

  task automatic model_edge(input logic fl, input logic iv, input logic [31:0] ins,
                            input logic [31:0] pc, input logic ordy);
    bit can_take;
    bit has_head;
    can_take = (mq.size() < 2);
    has_head = (mq.size() > 0);
    if (has_head && !ordy) m_stall++;
    if (fl) begin
      mq.delete();
    end else begin
      if (has_head && ordy) void'(mq.pop_front());
      if (iv && can_take) mq.push_back({ins, pc});
    end
  endtask

  initial begin
    //        fl  iv  ins            pc            ordy ov  e_ins          e_pc          occ  ir
    vecs[0]  = '{0, 1, 32'h00500093, 32'h00000000, 1,   1, 32'h00500093, 32'h00000000, 1, 1};
    vecs[1]  = '{0, 0, 32'h0,        32'h0,        1,   0, NOPW,         32'h00000000, 0, 1};
    vecs[2]  = '{0, 1, 32'hA0000001, 32'h00000000, 1,   1, 32'hA0000001, 32'h00000000, 1, 1};
    vecs[3]  = '{0, 1, 32'hA0000002, 32'h00000004, 1,   1, 32'hA0000002, 32'h00000004, 1, 1};
    vecs[4]  = '{0, 1, 32'hA0000003, 32'h00000008, 1,   1, 32'hA0000003, 32'h00000008, 1, 1};
    vecs[5]  = '{0, 1, 32'hA0000004, 32'h0000000C, 1,   1, 32'hA0000004, 32'h0000000C, 1, 1};
    vecs[6]  = '{0, 0, 32'h0,        32'h0,        1,   0, NOPW,         32'h00000000, 0, 1};
    vecs[7]  = '{0, 1, 32'hB0000001, 32'h00000010, 0,   1, 32'hB0000001, 32'h00000010, 1, 1};
    vecs[8]  = '{0, 1, 32'hB0000002, 32'h00000014, 0,   1, 32'hB0000001, 32'h00000010, 2, 0};
    vecs[9]  = '{0, 1, 32'hB0000003, 32'h00000018, 0,   1, 32'hB0000001, 32'h00000010, 2, 0};
    vecs[10] = '{0, 1, 32'hB0000003, 32'h00000018, 1,   1, 32'hB0000002, 32'h00000014, 1, 1};
    vecs[11] = '{0, 1, 32'hB0000003, 32'h00000018, 1,   1, 32'hB0000003, 32'h00000018, 1, 1};
    vecs[12] = '{0, 0, 32'h0,        32'h0,        1,   0, NOPW,         32'h00000000, 0, 1};
    vecs[13] = '{0, 1, 32'hC0000001, 32'h00000020, 0,   1, 32'hC0000001, 32'h00000020, 1, 1};
    vecs[14] = '{0, 1, 32'hC0000002, 32'h00000024, 0,   1, 32'hC0000001, 32'h00000020, 2, 0};
    vecs[15] = '{1, 1, 32'hC0000003, 32'h00000028, 0,   0, NOPW,         32'h00000000, 0, 1};
    vecs[16] = '{0, 1, 32'hC0000003, 32'h00000028, 1,   1, 32'hC0000003, 32'h00000028, 1, 1};
    vecs[17] = '{1, 1, 32'hC0000004, 32'h0000002C, 1,   0, NOPW,         32'h00000000, 0, 1};

    do_reset();

    // Directed table
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].ins, vecs[i].pc, vecs[i].ordy);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ins, vecs[i].e_pc,
                 vecs[i].e_occ, vecs[i].e_ir);
    end

    // Asynchronous reset mid-cycle with one entry buffered
    drive(1'b0, 1'b1, 32'hD0000001, 32'h00000040, 1'b0);
    step();
    check_outs("arst_pre", 1'b1, 32'hD0000001, 32'h00000040, 2'd1, 1'b1);
    drive(1'b0, 1'b1, 32'hD0000002, 32'h00000044, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("arst_now", 1'b0, NOPW, 32'd0, 2'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_outs("arst_first_edge", 1'b1, 32'hD0000002, 32'h00000044, 2'd1, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    step();

`ifdef FETCH_PIPE_PERF_EN
    do_reset();
    drive(1'b0, 1'b1, 32'hE0000001, 32'h00000050, 1'b0);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("stall_5", stall_count, 32'd5);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    step();
    step();
    chk("stall_hold", stall_count, 32'd5);
`endif

    // Randomized run against the list model
    do_reset();
    mq.delete();
    m_stall = 0;
    for (int c = 0; c < 2000; c++) begin
      logic        fl, iv, ordy;
      logic [31:0] ins, pc;
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      ins  = $urandom;
      pc   = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      drive(fl, iv, ins, pc, ordy);
      model_edge(fl, iv, ins, pc, ordy);
      step();
      if (mq.size() > 0)
        check_outs($sformatf("rnd%0d", c), 1'b1, mq[0][63:32], mq[0][31:0],
                   2'(mq.size()), mq.size() < 2);
      else
        check_outs($sformatf("rnd%0d", c), 1'b0, NOPW, 32'd0, 2'd0, 1'b1);
`ifdef FETCH_PIPE_PERF_EN
      chk($sformatf("rnd%0d.stall_count", c), stall_count, m_stall);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
